// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader and its memory.
package loader_pkg;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      HOLD = 2'd2,
      RUN  = 2'd3
   } state_t;

   localparam logic [7:0]  INST_IDLE = 8'h00;
   localparam int unsigned DATA_W    = 8;
   localparam int unsigned LEN_W     = 9;
   localparam int unsigned CNT_W     = 4;
endpackage

// File: rtl/prog_mem.sv
// Program store: synchronous write, asynchronous read, contents never reset.
module prog_mem
   import loader_pkg::*;
#(
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned ADDR_W = 8
) (
   input  logic              CLK,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata_c
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge CLK) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata_c = mem[raddr];

endmodule

// File: rtl/program_loader.sv
// Fills the program memory from a valid/ready byte stream and sequences
// the processor reset: held low while loading, released after a fixed delay.
module program_loader
   import loader_pkg::*;
#(
   parameter int unsigned DEPTH          = 256,
   parameter int unsigned ADDR_W         = 8,
   parameter int unsigned RELEASE_CYCLES = 4
) (
   input  logic              CLK,
   input  logic              CLB,
   input  logic [7:0]        PC,
   output logic [DATA_W-1:0] INST,
   input  logic              load_start,
   input  logic              load_valid,
   input  logic [DATA_W-1:0] load_data,
   input  logic              load_last,
   output logic              load_ready,
   output logic              cpu_clb,
   output logic [LEN_W-1:0]  prog_len,
   output logic              running
);

   localparam logic [ADDR_W-1:0] PTR_MAX  = ADDR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(RELEASE_CYCLES - 1);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [LEN_W-1:0]    len_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                accept_c;
   logic [DATA_W-1:0]   rdata_c;

   prog_mem #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .CLK     (CLK),
      .we      (accept_c),
      .waddr   (wr_ptr_q),
      .wdata   (load_data),
      .raddr   (PC[ADDR_W-1:0]),
      .rdata_c (rdata_c)
   );

   // Next-state, pointer, length and release-counter logic.
   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      len_d    = prog_len;
      cnt_d    = cnt_q;
      accept_c = load_valid & load_ready & (state_q == LOAD);
      unique case (state_q)
         IDLE: begin
            if (load_start) begin
               state_d  = LOAD;
               wr_ptr_d = '0;
               len_d    = '0;
            end
         end
         LOAD: begin
            if (accept_c) begin
               len_d = prog_len + LEN_W'(1);
               // The last slot ends the load even without load_last; never wrap.
               if (wr_ptr_q != PTR_MAX) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
               if (load_last || (wr_ptr_q == PTR_MAX)) begin
                  state_d = HOLD;
                  cnt_d   = CNT_INIT;
               end
            end
         end
         HOLD: begin
            if (cnt_q == '0) state_d = RUN;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         RUN: begin
            if (load_start) begin
               state_d  = LOAD;
               wr_ptr_d = '0;
               len_d    = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register; handshake and reset outputs are decoded from next state.
   always_ff @(posedge CLK or negedge CLB) begin
      if (!CLB) begin
         state_q    <= IDLE;
         wr_ptr_q   <= '0;
         prog_len   <= '0;
         cnt_q      <= '0;
         load_ready <= 1'b0;
         cpu_clb    <= 1'b0;
         running    <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         prog_len   <= len_d;
         cnt_q      <= cnt_d;
         load_ready <= (state_d == LOAD);
         cpu_clb    <= (state_d == RUN);
         running    <= (state_d == RUN);
      end
   end

   assign INST = (state_q == RUN) ? rdata_c : INST_IDLE;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader against a byte-level memory/length model.
module tb_program_loader;

   localparam int RC = 4;

   logic       CLK;
   logic       CLB;
   logic [7:0] PC;
   logic [7:0] INST;
   logic       load_start;
   logic       load_valid;
   logic [7:0] load_data;
   logic       load_last;
   logic       load_ready;
   logic       cpu_clb;
   logic [8:0] prog_len;
   logic       running;

   int checks = 0;
   int errors = 0;

   // Reference model: what memory should hold and where the load stands.
   logic [7:0] ref_mem   [256];
   bit         ref_known [256];
   bit         exp_ready;
   bit         exp_run;
   int         exp_ptr;
   int         exp_len;

   program_loader #(.DEPTH(256), .ADDR_W(8), .RELEASE_CYCLES(RC)) dut (
      .CLK        (CLK),
      .CLB        (CLB),
      .PC         (PC),
      .INST       (INST),
      .load_start (load_start),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_last  (load_last),
      .load_ready (load_ready),
      .cpu_clb    (cpu_clb),
      .prog_len   (prog_len),
      .running    (running)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #400000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   // One cycle with the given stream inputs; updates the model on acceptance.
   task automatic send_byte(input logic [7:0] d, input logic last, input logic v,
                            input logic st);
      bit acc;
      load_data  = d;
      load_last  = last;
      load_valid = v;
      load_start = st;
      checks++;
      if (load_ready !== exp_ready) begin
         errors++;
         $display("FAIL load_ready: got %b expected %b (ptr %0d)", load_ready, exp_ready, exp_ptr);
      end
      acc = v && exp_ready;
      @(posedge CLK); #1;
      load_valid = 1'b0;
      load_last  = 1'b0;
      load_start = 1'b0;
      if (acc) begin
         ref_mem[exp_ptr]   = d;
         ref_known[exp_ptr] = 1'b1;
         exp_len++;
         if (last || exp_ptr == 255) exp_ready = 1'b0;
         else                        exp_ptr++;
      end
   endtask

   task automatic start_load();
      load_start = 1'b1;
      @(posedge CLK); #1;
      load_start = 1'b0;
      exp_ready = 1'b1;
      exp_run   = 1'b0;
      exp_ptr   = 0;
      exp_len   = 0;
      checks++;
      if (load_ready !== 1'b1 || cpu_clb !== 1'b0 || running !== 1'b0 || prog_len !== 9'd0) begin
         errors++;
         $display("FAIL start: ready %b clb %b run %b len %0d, expected 1 0 0 0",
                  load_ready, cpu_clb, running, prog_len);
      end
   endtask

   // Called right after the last byte's edge: cpu_clb must rise exactly RC edges later.
   task automatic wait_release();
      for (int k = 1; k <= RC; k++) begin
         @(posedge CLK); #1;
         checks++;
         if (cpu_clb !== (k == RC) || running !== (k == RC)) begin
            errors++;
            $display("FAIL release edge %0d: cpu_clb %b running %b expected %b", k, cpu_clb,
                     running, (k == RC));
         end
      end
      exp_run = 1'b1;
   endtask

   task automatic check_inst(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         PC = 8'(i);
         #1;
         if (!exp_run || ref_known[i]) begin
            checks++;
            if (INST !== (exp_run ? ref_mem[i] : 8'h00)) begin
               errors++;
               $display("FAIL inst[%0d]: got %h expected %h", i, INST,
                        (exp_run ? ref_mem[i] : 8'h00));
            end
         end
      end
   endtask

   task automatic check_len(input string name);
      checks++;
      if (prog_len !== 9'(exp_len)) begin
         errors++;
         $display("FAIL %s prog_len: got %0d expected %0d", name, prog_len, exp_len);
      end
   endtask

   task automatic test_reset();
      CLB = 1'b0; PC = 8'h00; load_start = 1'b0; load_valid = 1'b0;
      load_data = 8'h00; load_last = 1'b0;
      exp_ready = 1'b0; exp_run = 1'b0; exp_ptr = 0; exp_len = 0;
      for (int i = 0; i < 256; i++) ref_known[i] = 1'b0;
      #12 CLB = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(posedge CLK); #1;
         PC = 8'($urandom);
         #1;
         checks++;
         if (cpu_clb !== 1'b0 || load_ready !== 1'b0 || running !== 1'b0 ||
             prog_len !== 9'd0 || INST !== 8'h00) begin
            errors++;
            $display("FAIL reset cycle %0d: clb %b ready %b run %b len %0d inst %h", c,
                     cpu_clb, load_ready, running, prog_len, INST);
         end
      end
   endtask

   task automatic test_basic();
      logic [7:0] d [3];
      d[0] = 8'h1A; d[1] = 8'h2B; d[2] = 8'h3C;
      start_load();
      for (int i = 0; i < 3; i++) send_byte(d[i], i == 2, 1'b1, 1'b0);
      check_len("basic");
      wait_release();
      check_inst(0, 2);
   endtask

   // Valid every other cycle, with a stray load_start on an idle beat.
   task automatic test_gapped();
      int n = 12;
      start_load();
      for (int i = 0; i < n; i++) begin
         send_byte(8'($urandom), 1'b0, 1'b0, i == 5);
         send_byte(8'($urandom), i == n - 1, 1'b1, 1'b0);
      end
      check_len("gapped");
      wait_release();
      check_inst(0, n - 1);
   endtask

   task automatic test_overflow();
      start_load();
      for (int i = 0; i < 300; i++) send_byte(8'($urandom), 1'b0, 1'b1, 1'b0);
      check_len("overflow");
      checks++;
      if (exp_len != 256 || running !== 1'b1 || cpu_clb !== 1'b1) begin
         errors++;
         $display("FAIL overflow end: model len %0d running %b cpu_clb %b expected 256 1 1",
                  exp_len, running, cpu_clb);
      end
      exp_run = 1'b1;
      check_inst(0, 255);
   endtask

   task automatic test_reload();
      start_load();
      PC = 8'd2;
      #1;
      checks++;
      if (cpu_clb !== 1'b0 || INST !== 8'h00) begin
         errors++;
         $display("FAIL reload entry: cpu_clb %b inst %h expected 0 00", cpu_clb, INST);
      end
      send_byte(8'($urandom), 1'b0, 1'b1, 1'b0);
      send_byte(8'($urandom), 1'b1, 1'b1, 1'b0);
      check_len("reload");
      wait_release();
      check_inst(0, 3);
   endtask

   task automatic test_reset_mid_load();
      start_load();
      for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b0, 1'b1, 1'b0);
      CLB = 1'b0;
      #2 CLB = 1'b1;
      exp_ready = 1'b0; exp_run = 1'b0; exp_len = 0;
      checks++;
      if (cpu_clb !== 1'b0 || load_ready !== 1'b0 || running !== 1'b0 || prog_len !== 9'd0) begin
         errors++;
         $display("FAIL mid reset: clb %b ready %b run %b len %0d expected 0 0 0 0",
                  cpu_clb, load_ready, running, prog_len);
      end
      for (int i = 5; i < 10; i++) send_byte(8'($urandom), i == 9, 1'b1, 1'b0);
      check_len("after reset");
      check_inst(0, 3);
      // A 1-byte load proves the ignored beats never reached memory.
      start_load();
      send_byte(8'($urandom), 1'b1, 1'b1, 1'b0);
      check_len("post reset load");
      wait_release();
      check_inst(0, 12);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_gapped();
      test_overflow();
      test_reload();
      test_reset_mid_load();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
